puf_arbiter_array: RTL and testbench

//  Parametrised arbiter-PUF front end: N_ARB arbiter chains share one CHAL_W-bit challenge.

---
 rtl/puf_pkg.sv | 24 ++
 rtl/puf_arbiter_chain.sv | 39 +++
 rtl/puf_arbiter_array.sv | 166 ++++++++++++++++
 tb/tb_puf_arbiter_array.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF front end.
//  - state_t    : evaluation FSM states
//  - MODE_*     : response combiner encodings (2'b11 falls back to MODE_RAW)
//  - DEF_SEED / DEF_TAPS : default challenge LFSR seed and Fibonacci tap mask
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXCITE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_VOTE,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_RAW = 2'b00;
  localparam logic [1:0] MODE_XOR = 2'b01;
  localparam logic [1:0] MODE_MAJ = 2'b10;

  localparam logic [31:0] DEF_SEED = 32'hACE1_0001;
  localparam logic [31:0] DEF_TAPS = 32'h8020_0003;

endpackage

// File: rtl/puf_arbiter_chain.sv
// Digital stand-in for one arbiter chain. The race outcome is modelled as the
// parity of the challenge bits selected by a per-chain mask (bit IDX). With
// JITTER=1 the outcome flips on every excite, emulating a metastable chain.
// The outcome is captured in a DFF on the excite cycle, as the real arbiter
// latch would be.
//  clk, rst   : clock, async active-low reset
//  challenge  : challenge applied to the delay stages
//  excite     : one-cycle launch pulse
//  dout       : captured race outcome
module puf_arbiter_chain
  import puf_pkg::*;
#(
  parameter int   IDX    = 0,
  parameter int   CHAL_W = 32,
  parameter logic JITTER = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAL_W-1:0] challenge,
  input  logic              excite,
  output logic              dout
);

  localparam logic [CHAL_W-1:0] ONE  = {{(CHAL_W-1){1'b0}}, 1'b1};
  localparam logic [CHAL_W-1:0] MASK = (IDX < CHAL_W) ? (ONE << IDX) : '0;

  logic tog;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= 1'b0;
      tog  <= 1'b0;
    end else if (excite) begin
      dout <= (^(challenge & MASK)) ^ (JITTER & tog);
      tog  <= ~tog;
    end
  end

endmodule

// File: rtl/puf_arbiter_array.sv
// Arbiter-PUF front end: N_ARB chains share one challenge, each challenge is
// evaluated N_EVAL times, per-chain results are majority-voted with an
// instability flag, and a single response bit is formed per the latched mode.
// Ports:
//  clk, rst           : clock, async active-low reset
//  start              : request evaluation (IDLE only)
//  chal_sel, chal_in  : challenge source select (0 LFSR, 1 chal_in) and bus
//  mode               : combiner select, latched with the challenge
//  resp_ack           : consumes the result while resp_valid=1
//  c_bits             : challenge applied to the chains
//  busy               : LOAD through VOTE
//  resp_valid         : DONE until acknowledged
//  resp, unstable     : per-chain voted response / disagreement flag
//  resp_bit           : combined response
module puf_arbiter_array
  import puf_pkg::*;
#(
  parameter int               N_ARB       = 4,
  parameter int               CHAL_W      = 32,
  parameter int               N_EVAL      = 5,
  parameter int               SETTLE_CYC  = 4,
  parameter logic [31:0]      LFSR_SEED   = DEF_SEED,
  parameter logic [31:0]      LFSR_TAPS   = DEF_TAPS,
  parameter logic [N_ARB-1:0] JITTER_MASK = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              chal_sel,
  input  logic [CHAL_W-1:0] chal_in,
  input  logic [1:0]        mode,
  input  logic              resp_ack,
  output logic [CHAL_W-1:0] c_bits,
  output logic              busy,
  output logic              resp_valid,
  output logic [N_ARB-1:0]  resp,
  output logic [N_ARB-1:0]  unstable,
  output logic              resp_bit
);

  localparam int CNT_W = $clog2(N_EVAL + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int PC_W  = $clog2(N_ARB + 1);

  localparam logic [CNT_W-1:0]  HALF    = CNT_W'(N_EVAL / 2);
  localparam logic [CNT_W-1:0]  ALL     = CNT_W'(N_EVAL);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(N_EVAL - 1);
  localparam logic [SET_W-1:0]  SET_END = SET_W'(SETTLE_CYC - 1);
  localparam logic [PC_W-1:0]   ARB_HLF = PC_W'(N_ARB / 2);
  localparam logic [CHAL_W-1:0] SEED_LO = LFSR_SEED[CHAL_W-1:0];
  localparam logic [CHAL_W-1:0] TAPS    = LFSR_TAPS[CHAL_W-1:0];
  // An all-zero Fibonacci LFSR would lock up.
  localparam logic [CHAL_W-1:0] SEED    = (SEED_LO == '0) ? {{(CHAL_W-1){1'b0}}, 1'b1} : SEED_LO;

  state_t                       state;
  logic [CHAL_W-1:0]            lfsr;
  logic                         sel_q;
  logic [1:0]                   mode_q;
  logic [SET_W-1:0]             set_cnt;
  logic [CNT_W-1:0]             eval_cnt;
  logic [N_ARB-1:0][CNT_W-1:0]  ones_cnt;
  logic [N_ARB-1:0]             dout;
  logic                         excite;

  assign excite = (state == ST_EXCITE);

  for (genvar i = 0; i < N_ARB; i++) begin : g_chain
    puf_arbiter_chain #(
      .IDX    (i),
      .CHAL_W (CHAL_W),
      .JITTER (JITTER_MASK[i])
    ) u_chain (
      .clk       (clk),
      .rst       (rst),
      .challenge (c_bits),
      .excite    (excite),
      .dout      (dout[i])
    );
  end

  // Vote and combine from the finished ones-counters; registered in VOTE.
  logic [N_ARB-1:0] resp_v, unst_v;
  logic [PC_W-1:0]  pc;
  logic             bit_v;

  always_comb begin
    resp_v = '0;
    unst_v = '0;
    pc     = '0;
    for (int i = 0; i < N_ARB; i++) begin
      resp_v[i] = (ones_cnt[i] > HALF);
      unst_v[i] = (ones_cnt[i] != '0) && (ones_cnt[i] != ALL);
      pc        = pc + PC_W'(resp_v[i]);
    end
    case (mode_q)
      MODE_XOR: bit_v = ^resp_v;
      MODE_MAJ: bit_v = (pc > ARB_HLF);   // ties resolve to 0
      default:  bit_v = resp_v[0];
    endcase
  end

  logic lfsr_fb;
  assign lfsr_fb = ^(lfsr & TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      lfsr       <= SEED;
      sel_q      <= 1'b0;
      mode_q     <= MODE_RAW;
      set_cnt    <= '0;
      eval_cnt   <= '0;
      ones_cnt   <= '0;
      c_bits     <= '0;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp       <= '0;
      unstable   <= '0;
      resp_bit   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          // Challenge and mode captured here; later bus changes are ignored.
          state    <= ST_LOAD;
          busy     <= 1'b1;
          sel_q    <= chal_sel;
          mode_q   <= mode;
          c_bits   <= chal_sel ? chal_in : lfsr;
          ones_cnt <= '0;
          eval_cnt <= '0;
        end
        ST_LOAD:   state <= ST_EXCITE;
        ST_EXCITE: begin
          set_cnt <= '0;
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (set_cnt == SET_END) state <= ST_SAMPLE;
          else                    set_cnt <= set_cnt + 1'b1;
        end
        ST_SAMPLE: begin
          for (int i = 0; i < N_ARB; i++)
            ones_cnt[i] <= ones_cnt[i] + CNT_W'(dout[i]);
          eval_cnt <= eval_cnt + 1'b1;
          state    <= (eval_cnt == LAST) ? ST_VOTE : ST_EXCITE;
        end
        ST_VOTE: begin
          resp       <= resp_v;
          unstable   <= unst_v;
          resp_bit   <= bit_v;
          busy       <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: if (resp_ack) begin
          // A start in the same cycle is dropped: state only reaches IDLE now.
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
          if (!sel_q) lfsr <= {lfsr[CHAL_W-2:0], lfsr_fb};
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_arbiter_array.sv
module tb_puf_arbiter_array;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, start_j = 1'b0;
  logic        chal_sel = 1'b0;
  logic [31:0] chal_in = '0;
  logic [1:0]  mode = 2'b00;
  logic        resp_ack = 1'b0, resp_ack_j = 1'b0;

  logic [31:0] c_bits, c_bits_j;
  logic        busy, busy_j, resp_valid, resp_valid_j, resp_bit, resp_bit_j;
  logic [3:0]  resp, resp_j, unstable, unstable_j;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  puf_arbiter_array dut (
    .clk(clk), .rst(rst), .start(start), .chal_sel(chal_sel), .chal_in(chal_in),
    .mode(mode), .resp_ack(resp_ack), .c_bits(c_bits), .busy(busy),
    .resp_valid(resp_valid), .resp(resp), .unstable(unstable), .resp_bit(resp_bit)
  );

  // Chain 2 flips its outcome on every excite.
  puf_arbiter_array #(.JITTER_MASK(4'b0100)) dut_j (
    .clk(clk), .rst(rst), .start(start_j), .chal_sel(chal_sel), .chal_in(chal_in),
    .mode(mode), .resp_ack(resp_ack_j), .c_bits(c_bits_j), .busy(busy_j),
    .resp_valid(resp_valid_j), .resp(resp_j), .unstable(unstable_j), .resp_bit(resp_bit_j)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Pulse start on the chosen instance; returns #1 after the accepting edge.
  task automatic launch(input bit j, input logic sel, input logic [31:0] ch, input logic [1:0] md);
    @(negedge clk);
    chal_sel = sel; chal_in = ch; mode = md;
    if (j) start_j = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_j = 1'b0;
  endtask

  // Counts further edges until resp_valid (bounded).
  task automatic wait_valid(input bit j, inout int n);
    while (!(j ? resp_valid_j : resp_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic ack(input bit j);
    @(negedge clk);
    if (j) resp_ack_j = 1'b1; else resp_ack = 1'b1;
    @(posedge clk); #1;
    resp_ack = 1'b0; resp_ack_j = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] chal;
    logic [1:0]  md;
    logic [3:0]  e_resp;
    logic [3:0]  e_unst;
    logic        e_bit;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{1'b1, 32'h0000_000F, 2'b00, 4'hF, 4'h0, 1'b1};
    vecs[1] = '{1'b1, 32'h0000_000F, 2'b01, 4'hF, 4'h0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0007, 2'b10, 4'h7, 4'h0, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_0003, 2'b10, 4'h3, 4'h0, 1'b0};  // 2 of 4: tie -> 0
    vecs[4] = '{1'b1, 32'h0000_0005, 2'b11, 4'h5, 4'h0, 1'b1};  // reserved = raw
    vecs[5] = '{1'b1, 32'h0000_000E, 2'b00, 4'hE, 4'h0, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_000B, 2'b01, 4'hB, 4'h0, 1'b1};
    vecs[7] = '{1'b1, 32'hFFFF_FFF0, 2'b10, 4'h0, 4'h0, 1'b0};

    // Reset state
    #12;
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cbits", c_bits, 32'h0);
    chk("rst_resp", 32'({resp, unstable, 3'b000, resp_bit}), 32'h0);
    @(negedge clk); rst = 1'b1;

    // LFSR source: seed, then one Fibonacci step after ack
    launch(1'b0, 1'b0, 32'h0, 2'b00);
    chk("lfsr_busy", 32'(busy), 32'h1);
    n = 0; wait_valid(1'b0, n);
    chk("lfsr_lat", n, 32);
    chk("lfsr_seed", c_bits, 32'hACE1_0001);
    chk("lfsr_resp0", 32'(resp), 32'h1);
    ack(1'b0);
    launch(1'b0, 1'b0, 32'h0, 2'b00);
    n = 0; wait_valid(1'b0, n);
    chk("lfsr_step", c_bits, 32'h59C2_0003);
    chk("lfsr_resp1", 32'(resp), 32'h3);
    ack(1'b0);

    // Table of directed vectors
    for (int k = 0; k < 8; k++) begin
      launch(1'b0, vecs[k].sel, vecs[k].chal, vecs[k].md);
      n = 0; wait_valid(1'b0, n);
      chk($sformatf("v%0d_lat", k), n, 32);
      chk($sformatf("v%0d_cbits", k), c_bits, vecs[k].chal);
      chk($sformatf("v%0d_resp", k), 32'(resp), 32'(vecs[k].e_resp));
      chk($sformatf("v%0d_unst", k), 32'(unstable), 32'(vecs[k].e_unst));
      chk($sformatf("v%0d_bit", k), 32'(resp_bit), 32'(vecs[k].e_bit));
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'h0);
      if (k == 0) begin
        // Held without ack for 3 cycles
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_valid", 32'(resp_valid), 32'h1);
        chk("hold_out", {resp, unstable, 3'b000, resp_bit, c_bits[19:0]}, 32'hF0_1_0000F);
      end
      ack(1'b0);
      chk($sformatf("v%0d_ackfall", k), 32'(resp_valid), 32'h0);
    end

    // Start while busy is ignored; bus changes after load have no effect;
    // start+ack together in DONE takes only the ack.
    launch(1'b0, 1'b1, 32'h0000_000F, 2'b00);
    n = 0;
    repeat (4) begin @(posedge clk); #1; n++; end
    @(negedge clk); start = 1'b1; chal_in = 32'h0; mode = 2'b01;
    @(posedge clk); #1; n++; start = 1'b0;
    wait_valid(1'b0, n);
    chk("busy_start_lat", n, 32);
    chk("busy_start_res", {resp, 3'b000, resp_bit, c_bits[23:0]}, 32'hF1_00000F);
    @(negedge clk); start = 1'b1; resp_ack = 1'b1;
    @(posedge clk); #1; start = 1'b0; resp_ack = 1'b0;
    chk("sa_valid", 32'(resp_valid), 32'h0);
    chk("sa_busy", 32'(busy), 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk("sa_no_rerun", 32'({busy, resp_valid}), 32'h0);

    // Jittery chain 2: outcomes 1,0,1,0,1 -> voted 1, flagged unstable
    launch(1'b1, 1'b1, 32'h0000_000F, 2'b00);
    n = 0; wait_valid(1'b1, n);
    chk("jit_lat", n, 32);
    chk("jit_resp", 32'(resp_j), 32'hF);
    chk("jit_unst", 32'(unstable_j), 32'h4);
    chk("jit_bit", 32'(resp_bit_j), 32'h1);
    ack(1'b1);

    // Reset during SETTLE of the third evaluation
    launch(1'b0, 1'b1, 32'h0000_000A, 2'b00);
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b0; #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_cbits", c_bits, 32'h0);
    chk("mid_rst_out", 32'({resp_valid, resp, unstable, resp_bit}), 32'h0);
    @(negedge clk); rst = 1'b1;
    launch(1'b0, 1'b1, 32'h0000_000A, 2'b10);
    n = 0; wait_valid(1'b0, n);
    chk("post_rst_lat", n, 32);
    chk("post_rst_resp", 32'({resp, unstable, resp_bit}), 32'({4'hA, 4'h0, 1'b0}));
    ack(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
